demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Sequencer for the 1:8, 16-bit demultiplexer: accepts a valid/ready word stream and dispatches each
//  word to one of 8 output channels. Drives the demux data input and selector, plus per-channel valid
//  strobes. Supports round-robin and fixed-target modes. Sits between the producer and the 8 consumers.
// PARAMETERS
//  DATA_W  16  word width (matches demux data path)
//  N_OUT   8   number of output channels
//  SEL_W   3   selector width, clog2(N_OUT)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  mode        in   1       0 = round-robin, 1 = fixed target
//  fixed_sel   in   SEL_W   target channel in fixed mode
//  enable      in   N_OUT   channel enable mask
//  in_valid    in   1       input word valid
//  in_data     in   DATA_W  input word
//  in_ready    out  1       input accept (comb.); transfer when in_valid & in_ready
//  out_data    out  DATA_W  held word, drives demux data input
//  sel         out  SEL_W   held target, drives demux selector
//  out_valid   out  N_OUT   one-hot valid for channel sel; all-zero when nothing held
//  out_ready   in   N_OUT   per-channel consumer ready
//  busy        out  1       1 while a word is held (state HOLD)
//  dispatch_cnt out 16      completed dispatches, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert not required here): state IDLE, out_data=0, sel=0,
//   out_valid=0, busy=0, rr_ptr=0, dispatch_cnt=0. in_ready forced 0 while rst_n=0.
//  FSM: IDLE (no word held), HOLD (one word held in output register).
//  Target pick (comb.): round-robin -> first channel c with enable[c]=1, searching rr_ptr, rr_ptr+1,
//   ... mod 8; fixed -> fixed_sel if enable[fixed_sel]=1. found=0 if no candidate.
//  done = (state==HOLD) & out_ready[sel].
//  in_ready = found & (state==IDLE | done). Back-to-back: one word per cycle when consumers ready.
//  Accept (in_valid & in_ready): out_data<=in_data, sel<=target, out_valid<=1<<target, state HOLD,
//   rr_ptr<=target+1 (wraps 7->0). Latency in->out_valid: 1 cycle.
//  done without accept: out_valid<=0, state IDLE; sel and out_data keep last value.
//  done (with or without accept): dispatch_cnt+=1.
//  HOLD & !out_ready[sel]: all outputs stable (out_data, sel, out_valid); in_ready=0.
//  mode, fixed_sel, enable sampled only at accept; clearing enable[sel] during HOLD does not
//   cancel the held word, it is still delivered.
//  enable=0 (or fixed target disabled): in_ready=0, block stalls in IDLE, no error flag.
//  Only one channel ever valid; out_ready of non-selected channels ignored.
//  Reset mid-HOLD: held word discarded, out_valid=0 immediately, counter cleared.
// STRUCTURE
//  Package demux_ctrl_pkg: localparams N_OUT, SEL_W, DATA_W; state enum {ST_IDLE, ST_HOLD}.
//  Sub-module rr_pick: comb. rotating priority search (mask, ptr -> idx, found); used for
//   round-robin pick. Demux itself instantiated at parent level, not inside this block.
// TESTING
//  Reset: rst_n=0 with in_valid=1 -> in_ready=0, out_valid=00, sel=0, dispatch_cnt=0.
//  RR: enable=FF, out_ready=FF, words 0xA000..0xA007 back-to-back -> sel 0..7 on consecutive
//   cycles, out_valid 01,02,..,80, in_ready stays 1, dispatch_cnt=8.
//  Mask skip: enable=8'b1001_0010, 4 words -> sel 1,4,7,1.
//  Backpressure: word 0xBEEF to ch2, out_ready[2]=0 for 5 cycles -> out_valid=04, out_data=BEEF
//   stable, in_ready=0; release -> done, cnt+1, next word accepted same cycle.
//  Fixed: mode=1, fixed_sel=5, enable[5]=0 -> in_ready=0; set enable[5] -> 3 words all sel=5.
//  Reset mid-HOLD: rst_n low while out_valid=08 -> out_valid=00 at once, word never delivered, cnt=0.

Source files
------------

// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared constants and types for the demux dispatch sequencer.
package demux_ctrl_pkg;

   localparam int DATA_W = 16;  // word width, matches the demux data path
   localparam int N_OUT  = 8;   // number of output channels
   localparam int SEL_W  = 3;   // selector width, clog2(N_OUT)
   localparam int CNT_W  = 16;  // dispatch counter width

   // IDLE: nothing held; HOLD: one word sits in the output register
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage : demux_ctrl_pkg

// File: rtl/demux_dispatch_ctrl_rr_pick.sv
// Rotating-priority search: first set bit of i_mask at or after i_ptr, modulo N_OUT.
module rr_pick
   import demux_ctrl_pkg::*;
(
   input  logic [N_OUT-1:0] i_mask,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_found
);

   logic [SEL_W-1:0] w_cand;

   // Scan from the farthest offset down so the candidate nearest to i_ptr wins last.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = N_OUT - 1; k >= 0; k--) begin
         w_cand = SEL_W'((int'(i_ptr) + k) % N_OUT);
         if (i_mask[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule : rr_pick

// File: rtl/demux_dispatch_ctrl.sv
// Sequencer for a 1:8 demux: takes a valid/ready word stream, holds one word and
// dispatches it to a channel chosen round-robin or fixed, with per-channel valids.
module demux_dispatch_ctrl
   import demux_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SEL_W-1:0]  fixed_sel,
   input  logic [N_OUT-1:0]  enable,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  sel,
   output logic [N_OUT-1:0]  out_valid,
   input  logic [N_OUT-1:0]  out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  dispatch_cnt
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DATA_W-1:0]  r_data;
   logic [SEL_W-1:0]   r_sel;
   logic [N_OUT-1:0]   r_valid;
   logic [SEL_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_cnt;

   logic [SEL_W-1:0]   w_rr_idx;
   logic               w_rr_found;
   logic [SEL_W-1:0]   w_target;
   logic               w_found;
   logic               w_done;
   logic               w_accept;

   rr_pick u_rr_pick (
      .i_mask  (enable),
      .i_ptr   (r_ptr),
      .o_idx   (w_rr_idx),
      .o_found (w_rr_found)
   );

   // Target selection and handshake decode; config inputs only matter on the accept cycle.
   always_comb begin
      w_target = mode ? fixed_sel : w_rr_idx;
      w_found  = mode ? enable[fixed_sel] : w_rr_found;
      w_done   = (r_state == ST_HOLD) && out_ready[r_sel];
      w_accept = in_valid && in_ready;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: an accept always leads to HOLD; a bare completion returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_accept)    w_state_nxt = ST_HOLD;
         ST_HOLD: if (w_accept)    w_state_nxt = ST_HOLD;
                  else if (w_done) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: accept when a target exists and the slot is empty or emptying this cycle.
   always_comb begin
      in_ready     = rst_n && w_found && ((r_state == ST_IDLE) || w_done);
      busy         = (r_state == ST_HOLD);
      out_data     = r_data;
      sel          = r_sel;
      out_valid    = r_valid;
      dispatch_cnt = r_cnt;
   end

   // Held word, target and one-hot valid; data and selector keep their value after delivery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= '0;
         r_ptr   <= '0;
      end else if (w_accept) begin
         r_data  <= in_data;
         r_sel   <= w_target;
         r_valid <= N_OUT'(1) << w_target;
         r_ptr   <= (w_target == SEL_W'(N_OUT - 1)) ? '0 : w_target + 1'b1;
      end else if (w_done) begin
         r_valid <= '0;
      end
   end

   // Completed-dispatch counter, free-running wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_done) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : demux_dispatch_ctrl

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl: a reference model predicts each accept,
// pushes the expected delivery, and a monitor pops and compares on every delivery.
module tb_demux_dispatch_ctrl;
   import demux_ctrl_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              mode;
   logic [SEL_W-1:0]  fixed_sel;
   logic [N_OUT-1:0]  enable;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  sel;
   logic [N_OUT-1:0]  out_valid;
   logic [N_OUT-1:0]  out_ready;
   logic              busy;
   logic [CNT_W-1:0]  dispatch_cnt;

   demux_dispatch_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode         (mode),
      .fixed_sel    (fixed_sel),
      .enable       (enable),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .sel          (sel),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .dispatch_cnt (dispatch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                ch;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   int   m_ptr  = 0;
   bit   m_hold = 0;
   int   m_ch   = 0;
   int   m_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model + monitor: evaluated mid-cycle when inputs and combinational outputs are settled.
   always @(negedge clk) begin
      bit   found;
      int   tgt;
      bit   done;
      bit   exp_ready;
      exp_t e;
      if (!rst_n) begin
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_sel", sel, 0);
         check("rst_cnt", dispatch_cnt, 0);
         check("rst_busy", busy, 0);
         exp_q.delete();
         m_ptr = 0; m_hold = 0; m_ch = 0; m_cnt = 0;
      end else begin
         found = 0;
         tgt   = 0;
         if (mode) begin
            if (enable[fixed_sel]) begin found = 1; tgt = int'(fixed_sel); end
         end else begin
            for (int k = 0; k < N_OUT; k++) begin
               if (!found && enable[(m_ptr + k) % N_OUT]) begin
                  found = 1;
                  tgt   = (m_ptr + k) % N_OUT;
               end
            end
         end
         done      = m_hold && out_ready[m_ch];
         exp_ready = found && (!m_hold || done);

         check("in_ready", in_ready, exp_ready);
         check("busy", busy, m_hold);
         check("dispatch_cnt", dispatch_cnt, m_cnt % 65536);
         check("out_valid", out_valid, m_hold ? (32'd1 << m_ch) : 32'd0);
         if (m_hold && exp_q.size() > 0)
            check("held_data", out_data, exp_q[0].data);

         if (out_valid != 0 && out_ready[sel]) begin
            if (exp_q.size() == 0) begin
               check("spurious_delivery", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("deliver_sel", sel, e.ch);
               check("deliver_data", out_data, e.data);
            end
         end

         if (done) begin
            m_cnt++;
            m_hold = 0;
         end
         if (in_valid && exp_ready) begin
            e.data = in_data;
            e.ch   = tgt;
            exp_q.push_back(e);
            m_hold = 1;
            m_ch   = tgt;
            m_ptr  = (tgt + 1) % N_OUT;
         end
      end
   end

   // Hold in_valid until the word is accepted, bounded by a cycle budget.
   task automatic wait_accept();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      wait_accept();
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      fixed_sel = '0;
      enable    = 8'hFF;
      in_valid  = 1'b1;
      in_data   = 16'hFFFF;
      out_ready = 8'hFF;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Round-robin sweep, back-to-back
      for (int i = 0; i < 8; i++) send(16'hA000 + 16'(i));
      @(posedge clk); #1;
      check("rr_cnt", dispatch_cnt, 8);

      // Mask skip
      enable = 8'b1001_0010;
      for (int i = 0; i < 4; i++) send(16'hB100 + 16'(i));

      // Backpressure on channel 2, next word waiting
      mode = 1'b1; fixed_sel = 3'd2; enable = 8'hFF;
      out_ready = 8'hFB;
      send(16'hBEEF);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      repeat (5) @(posedge clk);
      #1;
      out_ready = 8'hFF;
      wait_accept();

      // Fixed target disabled, then enabled
      repeat (2) @(posedge clk);
      #1;
      fixed_sel = 3'd5; enable = 8'hDF;
      in_valid = 1'b1; in_data = 16'h5555;
      repeat (4) @(posedge clk);
      #1;
      enable = 8'hFF;
      for (int i = 0; i < 3; i++) send(16'hC500 + 16'(i));

      // Reset while holding a word for channel 3
      @(posedge clk); #1;
      fixed_sel = 3'd3; out_ready = 8'hF7;
      send(16'hCAFE);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midhold_out_valid", out_valid, 0);
      check("midhold_cnt", dispatch_cnt, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 8'hFF;
      repeat (3) @(posedge clk);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         mode      = ($urandom_range(0, 3) == 0);
         fixed_sel = SEL_W'($urandom);
         enable    = ($urandom_range(0, 9) == 0) ? '0 : N_OUT'($urandom);
         out_ready = N_OUT'($urandom);
         in_valid  = $urandom_range(0, 1) == 1;
         in_data   = DATA_W'($urandom);
      end

      // Drain
      @(posedge clk); #1;
      in_valid = 1'b0; enable = 8'hFF; out_ready = 8'hFF;
      repeat (4) @(posedge clk);
      #1;
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_busy", busy, 0);
      check("drain_cnt", dispatch_cnt, m_cnt % 65536);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_demux_dispatch_ctrl
